// File: rtl/sevenseg_pkg.sv
// Shared types, segment constants and the BCD-to-7-segment lookup for the
// Basys3 scan driver. All segment patterns are active-low {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pat;
        pat = SEG_DASH;
        case (bcd)
            4'd0: pat = 7'b1000000;
            4'd1: pat = 7'b1111001;
            4'd2: pat = 7'b0100100;
            4'd3: pat = 7'b0110000;
            4'd4: pat = 7'b0011001;
            4'd5: pat = 7'b0010010;
            4'd6: pat = 7'b0000010;
            4'd7: pat = 7'b1111000;
            4'd8: pat = 7'b0000000;
            4'd9: pat = 7'b0010000;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD decoder; invalid codes (10..15) render as a dash.
module bcd_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit common-anode scan driver: BLANK dead time then SHOW per slot,
// frame-coherent digit snapshot, leading-zero blanking and a blinking MM.SS dot.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1_000,
    parameter int BLANK_CYCLES = 1_000,
    parameter int BLINK_HZ     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic       lz_blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SLOT    = CLK_HZ / REFRESH_HZ;
    localparam int DWELL   = SLOT - BLANK_CYCLES;
    localparam int CNT_MAX = ((BLANK_CYCLES > DWELL) ? BLANK_CYCLES : DWELL) - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLK_W   = (HALF < 2) ? 1 : $clog2(HALF);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(HALF - 1);

    if (DWELL < 1) begin : g_bad_dwell
        $error("sevenseg_scan_driver: DWELL must be >= 1");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("sevenseg_scan_driver: BLANK_CYCLES must be >= 1");
    end
    if (HALF < 1) begin : g_bad_blink
        $error("sevenseg_scan_driver: blink half-period must be >= 1");
    end

    scan_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0][3:0]      shadow_q, shadow_d;
    logic                 shadow_lz_q, shadow_lz_d;
    logic [BLK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                 blink_q, blink_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 capture;
    logic [6:0]           dec_seg;

    bcd_to_7seg u_dec (
        .bcd_i (shadow_q[idx_q]),
        .seg_o (dec_seg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    capture = (idx_q == 2'd0);
                end
            end
            SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        shadow_d    = shadow_q;
        shadow_lz_d = shadow_lz_q;
        if (capture) begin
            shadow_d    = {digit3, digit2, digit1, digit0};
            shadow_lz_d = lz_blank;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
        blink_d     = blink_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    // Outputs are built from the current state and registered together, so
    // an/seg/dp always move on the same edge, one cycle behind the FSM.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == SHOW) begin
            an_d[idx_q] = 1'b0;
            seg_d = (idx_q == 2'd3 && shadow_lz_q && shadow_q[3] == 4'd0) ? SEG_OFF : dec_seg;
            dp_d  = ~(idx_q == 2'd2 && blink_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            shadow_q    <= '0;
            shadow_lz_q <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_lz_q <= shadow_lz_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver at SLOT=10, DWELL=8, blink half-period 20:
// constant tables, hand sequences and a cycle-count based reference model.
module tb_sevenseg_scan_driver;

    localparam int FRAME = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dg [4];
    logic       lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    sevenseg_scan_driver #(
        .CLK_HZ       (1000),
        .REFRESH_HZ   (100),
        .BLANK_CYCLES (2),
        .BLINK_HZ     (25)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .digit0   (dg[0]),
        .digit1   (dg[1]),
        .digit2   (dg[2]),
        .digit3   (dg[3]),
        .lz_blank (lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [6:0] seg;
    } dec_vec_t;

    dec_vec_t   vecs [16];
    logic [6:0] ref_dec [16];
    int         cmp_cnt = 0;
    int         err_cnt = 0;
    int         t = 0;          // posedges since reset release
    logic [3:0] snap [4];
    logic       snap_lz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    function automatic int pos();
        return (t - 1) % FRAME;
    endfunction

    // Output after edge t reflects scan position of cycle s=t-1: ten cycles per
    // digit, the first two dark; dot phase flips every 20 cycles.
    task automatic model_check();
        int s, p, idx, w;
        logic ph;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        s   = t - 1;
        p   = s % FRAME;
        idx = p / 10;
        w   = p % 10;
        ph  = ((s / 20) % 2) == 1;
        e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
        if (w >= 2) begin
            e_an = 4'b1111 & ~(4'b0001 << idx);
            if (idx == 3 && snap_lz && snap[3] == 4'd0) e_seg = 7'h7F;
            else e_seg = ref_dec[snap[idx]];
            e_dp = !(idx == 2 && ph);
        end
        chk("model_an", {28'd0, an}, {28'd0, e_an});
        chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
        chk("model_dp", {31'd0, dp}, {31'd0, e_dp});
        chk("onehot_an", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (t % FRAME == 1) begin
            for (int i = 0; i < 4; i++) snap[i] = dg[i];
            snap_lz = lz;
        end
        t++;
        @(negedge clk);
        model_check();
    endtask

    task automatic advance_to(input int p);
        bit hit;
        hit = 0;
        for (int n = 0; n < FRAME + 1; n++) begin
            tick();
            if (pos() == p) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk("advance_timeout", 32'd0, 32'd1);
    endtask

    task automatic next_frame_at(input int p);
        advance_to(FRAME - 1);
        advance_to(p);
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
        snap_lz = 1'b0;
    endtask

    logic [3:0] ord_an  [4];
    logic [6:0] ord_seg [4];

    initial begin
        ref_dec[0] = 7'b1000000; ref_dec[1] = 7'b1111001; ref_dec[2] = 7'b0100100;
        ref_dec[3] = 7'b0110000; ref_dec[4] = 7'b0011001; ref_dec[5] = 7'b0010010;
        ref_dec[6] = 7'b0000010; ref_dec[7] = 7'b1111000; ref_dec[8] = 7'b0000000;
        ref_dec[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) ref_dec[i] = 7'b0111111;
        for (int i = 0; i < 16; i++) begin
            vecs[i].d   = 4'(i);
            vecs[i].seg = ref_dec[i];
        end
        ord_an[0] = 4'b1110; ord_an[1] = 4'b1101; ord_an[2] = 4'b1011; ord_an[3] = 4'b0111;
        ord_seg[0] = 7'b1000000; ord_seg[1] = 7'b1111001;
        ord_seg[2] = 7'b0100100; ord_seg[3] = 7'b0110000;

        // Reset held with all digits at 5
        reset = 1'b1; lz = 1'b0;
        for (int i = 0; i < 4; i++) dg[i] = 4'h5;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i <= 2 || i > 10) chk("rel_blank_an", {28'd0, an}, 32'hF);
            else begin
                chk("rel_show_an", {28'd0, an}, 32'hE);
                chk("rel_show_seg", {25'd0, seg}, {25'd0, 7'b0010010});
            end
        end

        // Anode order and decode with digits 3,2,1,0
        dg[3] = 4'd3; dg[2] = 4'd2; dg[1] = 4'd1; dg[0] = 4'd0;
        next_frame_at(0);
        for (int k = 0; k < 4; k++) begin
            advance_to(k * 10 + 5);
            chk("order_an", {28'd0, an}, {28'd0, ord_an[k]});
            chk("order_seg", {25'd0, seg}, {25'd0, ord_seg[k]});
        end
        advance_to(25);
        chk("dp_idx2_on", {31'd0, dp}, 32'd0);
        advance_to(15);
        chk("dp_idx1_off", {31'd0, dp}, 32'd1);

        // Leading-zero blank then unblank
        dg[3] = 4'd0; lz = 1'b1;
        next_frame_at(35);
        chk("lz_an", {28'd0, an}, 32'h7);
        chk("lz_seg", {25'd0, seg}, 32'h7F);
        lz = 1'b0;
        next_frame_at(35);
        chk("nolz_seg", {25'd0, seg}, {25'd0, 7'b1000000});

        // Mid-frame change must not tear the frame
        dg[1] = 4'd4;
        next_frame_at(13);
        chk("tear_before", {25'd0, seg}, {25'd0, 7'b0011001});
        dg[1] = 4'd5;
        advance_to(17);
        chk("tear_hold", {25'd0, seg}, {25'd0, 7'b0011001});
        next_frame_at(15);
        chk("tear_next", {25'd0, seg}, {25'd0, 7'b0010010});

        // Decode table through digit0
        for (int i = 0; i < 16; i++) begin
            dg[0] = vecs[i].d;
            advance_to(0);
            advance_to(5);
            chk("decode_tbl", {25'd0, seg}, {25'd0, vecs[i].seg});
        end

        // Async reset in the middle of index 2 SHOW
        advance_to(25);
        #2 reset = 1'b1;
        #1;
        chk("arst_an", {28'd0, an}, 32'hF);
        chk("arst_seg", {25'd0, seg}, 32'h7F);
        chk("arst_dp", {31'd0, dp}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("arst_hold_an", {28'd0, an}, 32'hF);
        reset = 1'b0;
        model_reset();
        for (int i = 1; i <= 3; i++) tick();
        chk("arst_restart_an", {28'd0, an}, 32'hE);

        // Randomized digits, lz and change timing
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++) dg[i] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) dg[3] = 4'd0;
            lz = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 60)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
